// File: rtl/ritc_idelay_ctrl_v3_if.sv
// Register bus between the RITC control fabric and the IDELAY control engine.
interface ritc_idelay_ctrl_v3_if;
    logic [1:0]  addr_i;
    logic [31:0] dat_i;
    logic        wr_i;
    logic [31:0] dat_o;

    modport master (output addr_i, output dat_i, output wr_i, input dat_o);
    modport slave  (input addr_i, input dat_i, input wr_i, output dat_o);
endinterface

// File: rtl/ritc_idelay_ctrl_v3.sv
// IDELAYE2 tap load sequencer with shadow taps and IDELAYCTRL reset/ready sequencing.
// Optional macro RITC_IDELAY_BCAST_EN enables lane/channel broadcast loads.
module ritc_idelay_ctrl_v3 #(
    parameter int unsigned NUM_CH      = 6,
    parameter int unsigned NUM_BITS    = 12,
    parameter int unsigned DELAY_W     = 5,
    parameter int unsigned RST_LEN     = 16,
    parameter int unsigned RDY_TIMEOUT = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    ritc_idelay_ctrl_v3_if.slave             bus,
    output logic                             busy_o,
    output logic [DELAY_W-1:0]               cntvalue_o,
    output logic [NUM_CH*(NUM_BITS+1)-1:0]   ld_o,
    output logic                             idelayctrl_rst_o,
    input  logic [NUM_CH-1:0]                idelayctrl_rdy_i
);
    localparam int unsigned LPC   = NUM_BITS + 1;
    localparam int unsigned RST_W = $clog2(RST_LEN) + 1;
    localparam int unsigned TO_W  = $clog2(RDY_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOAD, S_HOLD, S_RST, S_WAIT_RDY
    } state_t;

    state_t                   state;
    logic [RST_W-1:0]         rst_cnt;
    logic [TO_W-1:0]          to_cnt;
    logic [7:0]               ch_q, lane_q, ptr_ch, ptr_lane;
    logic                     bl_q, bc_q;
    logic                     cmd_err, rdy_to;
    logic [31:0]              cmd_q;
    logic [DELAY_W-1:0]       shadow [NUM_CH][LPC];
    logic [NUM_CH-1:0][LPC-1:0] hit;
    logic [DELAY_W-1:0]       rd_tap;

    logic       wr0, wr1, wr2, go_req, rst_req, clr_req;
    logic [7:0] ch_in, lane_in;
    logic       bl_in, bc_in, range_bad, busy_now;
    logic       go_ok, go_err, rst_ok, rst_err;

    assign wr0     = bus.wr_i && (bus.addr_i == 2'd0);
    assign wr1     = bus.wr_i && (bus.addr_i == 2'd1);
    assign wr2     = bus.wr_i && (bus.addr_i == 2'd2);
    assign go_req  = wr1 && bus.dat_i[31];
    assign rst_req = wr0 && bus.dat_i[0];
    assign clr_req = wr0 && bus.dat_i[1];
    assign ch_in   = bus.dat_i[23:16];
    assign lane_in = bus.dat_i[15:8];
`ifdef RITC_IDELAY_BCAST_EN
    assign bl_in = bus.dat_i[24];
    assign bc_in = bus.dat_i[25];
`else
    assign bl_in = 1'b0;
    assign bc_in = 1'b0;
`endif
    // Broadcast bits waive the range check on the field they replace
    assign range_bad = (!bc_in && (ch_in >= 8'(NUM_CH))) ||
                       (!bl_in && (lane_in > 8'(NUM_BITS)));
    assign busy_now  = (state != S_IDLE);
    assign go_ok     = go_req && !busy_now && !range_bad;
    assign go_err    = go_req && (busy_now || range_bad);
    assign rst_ok    = rst_req && !busy_now;
    assign rst_err   = rst_req && busy_now;

    // Lane selection mask for the latched command, ch-major like ld_o
    always_comb begin
        hit = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int l = 0; l < LPC; l++)
                hit[c][l] = (bc_q || (ch_q == 8'(c))) && (bl_q || (lane_q == 8'(l)));
    end

    always_comb begin
        rd_tap = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int l = 0; l < LPC; l++)
                if ((ptr_ch == 8'(c)) && (ptr_lane == 8'(l)))
                    rd_tap = shadow[c][l];
    end

    always_comb begin
        bus.dat_o = '0;
        case (bus.addr_i)
            2'd0: bus.dat_o = {12'd0, rdy_to, cmd_err, idelayctrl_rst_o, busy_o,
                               16'(idelayctrl_rdy_i)};
            2'd1: bus.dat_o = cmd_q;
            2'd2: bus.dat_o = 32'(rd_tap);
            default: bus.dat_o = {8'h03, 8'(NUM_CH), 8'(NUM_BITS), 8'(DELAY_W)};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            busy_o           <= 1'b0;
            cntvalue_o       <= '0;
            ld_o             <= '0;
            idelayctrl_rst_o <= 1'b0;
            rst_cnt          <= '0;
            to_cnt           <= '0;
            ch_q             <= '0;
            lane_q           <= '0;
            bl_q             <= 1'b0;
            bc_q             <= 1'b0;
            ptr_ch           <= '0;
            ptr_lane         <= '0;
            cmd_err          <= 1'b0;
            rdy_to           <= 1'b0;
            cmd_q            <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int l = 0; l < LPC; l++)
                    shadow[c][l] <= '0;
        end else begin
            ld_o <= '0;
            if (wr2) begin
                ptr_ch   <= bus.dat_i[23:16];
                ptr_lane <= bus.dat_i[15:8];
            end
            // Clear first so a coincident error event overrides it
            if (clr_req) begin
                cmd_err <= 1'b0;
                rdy_to  <= 1'b0;
            end
            if (go_err || rst_err)
                cmd_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (go_ok) begin
                        cmd_q      <= bus.dat_i;
                        cntvalue_o <= bus.dat_i[DELAY_W-1:0];
                        ch_q       <= ch_in;
                        lane_q     <= lane_in;
                        bl_q       <= bl_in;
                        bc_q       <= bc_in;
                        busy_o     <= 1'b1;
                        state      <= S_SETUP;
                    end else if (rst_ok) begin
                        idelayctrl_rst_o <= 1'b1;
                        rst_cnt          <= RST_W'(RST_LEN - 1);
                        busy_o           <= 1'b1;
                        state            <= S_RST;
                    end
                end
                S_SETUP: begin
                    ld_o <= hit;
                    for (int c = 0; c < NUM_CH; c++)
                        for (int l = 0; l < LPC; l++)
                            if (hit[c][l])
                                shadow[c][l] <= cntvalue_o;
                    state <= S_LOAD;
                end
                S_LOAD: state <= S_HOLD;
                S_HOLD: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                S_RST: begin
                    if (rst_cnt == '0) begin
                        idelayctrl_rst_o <= 1'b0;
                        to_cnt           <= '0;
                        state            <= S_WAIT_RDY;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (&idelayctrl_rdy_i) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else if (to_cnt == TO_W'(RDY_TIMEOUT - 1)) begin
                        rdy_to <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ritc_idelay_ctrl_v3.sv
// Bench for ritc_idelay_ctrl_v3: cycle-offset model of the load and reset sequences plus pinned literals.
module tb_ritc_idelay_ctrl_v3;
    localparam int NCH = 6;
    localparam int NB  = 12;
    localparam int LPC = NB + 1;
    localparam int LDW = NCH * LPC;
    localparam int RL  = 16;
    localparam int TO  = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic           busy_o, idelayctrl_rst_o;
    logic [4:0]     cntvalue_o;
    logic [LDW-1:0] ld_o;
    logic [NCH-1:0] rdy;

    ritc_idelay_ctrl_v3_if bus ();

    ritc_idelay_ctrl_v3 dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus             (bus),
        .busy_o          (busy_o),
        .cntvalue_o      (cntvalue_o),
        .ld_o            (ld_o),
        .idelayctrl_rst_o(idelayctrl_rst_o),
        .idelayctrl_rdy_i(rdy)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Model state: outputs expected after each rising edge, derived from cycle offsets
    int             ec = 0;
    int             m_op = 0;      // 0 none, 1 tap load, 2 idelayctrl reset
    int             m_start = 0;
    bit             chk_en = 0;
    logic [LDW-1:0] m_mask, exp_ld;
    logic [4:0]     exp_cnt;
    logic           exp_busy, exp_rst, m_err, m_to;
    logic [31:0]    m_cmd;
    logic [7:0]     m_pch, m_plane;
    logic [4:0]     m_sh [NCH][LPC];

    always @(posedge clk) begin
        logic busy_before, bad, bl, bc;
        int d, c, l;
        ec++;
        if (rst) begin
            m_op = 0; exp_ld = '0; exp_cnt = '0; exp_busy = 0; exp_rst = 0;
            m_err = 0; m_to = 0; m_cmd = '0; m_pch = '0; m_plane = '0; m_mask = '0;
            for (int i = 0; i < NCH; i++)
                for (int j = 0; j < LPC; j++)
                    m_sh[i][j] = '0;
            chk_en = 1;
        end else begin
            busy_before = (m_op != 0);
            exp_ld = '0;
            if (bus.wr_i && bus.addr_i == 2'd0 && bus.dat_i[1]) begin
                m_err = 0; m_to = 0;
            end
            if (m_op == 1) begin
                d = ec - m_start;
                if (d == 1) begin
                    exp_ld = m_mask;
                    for (int i = 0; i < NCH; i++)
                        for (int j = 0; j < LPC; j++)
                            if (m_mask[i*LPC+j]) m_sh[i][j] = exp_cnt;
                end
                if (d == 3) m_op = 0;
            end else if (m_op == 2) begin
                d = ec - m_start;
                exp_rst = (d < RL);
                if (d >= RL + 1) begin
                    if (&rdy) m_op = 0;
                    else if (d - RL - 1 == TO - 1) begin m_to = 1; m_op = 0; end
                end
            end
            if (bus.wr_i && bus.addr_i == 2'd1 && bus.dat_i[31]) begin
                c = int'(bus.dat_i[23:16]);
                l = int'(bus.dat_i[15:8]);
`ifdef RITC_IDELAY_BCAST_EN
                bl = bus.dat_i[24]; bc = bus.dat_i[25];
`else
                bl = 0; bc = 0;
`endif
                bad = (!bc && c >= NCH) || (!bl && l > NB);
                if (busy_before || bad) m_err = 1;
                else begin
                    m_op = 1; m_start = ec; m_cmd = bus.dat_i; exp_cnt = bus.dat_i[4:0];
                    m_mask = '0;
                    for (int i = 0; i < NCH; i++)
                        for (int j = 0; j < LPC; j++)
                            if ((bc || i == c) && (bl || j == l)) m_mask[i*LPC+j] = 1'b1;
                end
            end
            if (bus.wr_i && bus.addr_i == 2'd0 && bus.dat_i[0]) begin
                if (busy_before) m_err = 1;
                else begin m_op = 2; m_start = ec; exp_rst = 1; end
            end
            if (bus.wr_i && bus.addr_i == 2'd2) begin
                m_pch = bus.dat_i[23:16]; m_plane = bus.dat_i[15:8];
            end
            exp_busy = (m_op != 0);
        end
    end

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0: return {12'd0, m_to, m_err, exp_rst, exp_busy, 10'd0, rdy};
            2'd1: return m_cmd;
            2'd2: return (int'(m_pch) < NCH && int'(m_plane) < LPC) ?
                         32'(m_sh[m_pch][m_plane]) : 32'd0;
            default: return {8'h03, 8'(NCH), 8'(NB), 8'd5};
        endcase
    endfunction

    // Per-cycle output compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", busy_o, exp_busy);
            chk("cyc_cnt", cntvalue_o, exp_cnt);
            chk("cyc_ld", ld_o, exp_ld);
            chk("cyc_rst", idelayctrl_rst_o, exp_rst);
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.addr_i = a; bus.dat_i = d; bus.wr_i = 1'b1;
        @(negedge clk);
        bus.wr_i = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string nm);
        bus.addr_i = a; #1;
        chk(nm, bus.dat_o, model_rd(a));
    endtask

    task automatic rd_lit(input logic [1:0] a, input string nm, input logic [31:0] e);
        bus.addr_i = a; #1;
        chk(nm, bus.dat_o, e);
        chk({nm, "_model"}, bus.dat_o, model_rd(a));
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy_o !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk(nm, busy_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [LDW-1:0] one = 1;
        rst = 1'b1; rdy = '0;
        bus.wr_i = 1'b0; bus.addr_i = '0; bus.dat_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_lit(2'd0, "rst_status", 32'h0);
        rd_lit(2'd3, "id_word", 32'h0306_0C05);
        rd_lit(2'd1, "rst_cmd", 32'h0);

        // single load ch2 lane5 tap 0x13
        bus_write(2'd1, 32'h8002_0513);
        chk("n1_busy", busy_o, 1);
        chk("n1_cnt", cntvalue_o, 5'h13);
        @(negedge clk);
        chk("n2_ld", ld_o, one << 31);
        @(negedge clk);
        chk("n3_ld", ld_o, 0);
        chk("n3_cnt", cntvalue_o, 5'h13);
        @(negedge clk);
        chk("n4_busy", busy_o, 0);
        bus_write(2'd2, 32'h0002_0500);
        rd_lit(2'd2, "shadow_2_5", 32'h13);
        rd_lit(2'd1, "cmd_rb", 32'h8002_0513);

        // clock lane
        bus_write(2'd1, 32'h8000_0C07);
        @(negedge clk);
        chk("clk_lane_ld", ld_o, one << 12);
        wait_idle("idle_clk_lane");
        bus_write(2'd2, 32'h0000_0C00);
        rd_lit(2'd2, "shadow_0_12", 32'h7);

        // out-of-range channel and lane
        bus_write(2'd1, 32'h8006_0001);
        repeat (3) @(negedge clk);
        rd_lit(2'd0, "err_ch", 32'h0004_0000);
        bus_write(2'd0, 32'h2);
        rd_lit(2'd0, "err_clr", 32'h0);
        bus_write(2'd1, 32'h8000_0D01);
        repeat (3) @(negedge clk);
        rd_lit(2'd0, "err_lane", 32'h0004_0000);
        bus_write(2'd2, 32'h0000_0D00);
        rd_lit(2'd2, "oor_ptr", 32'h0);
        bus_write(2'd0, 32'h2);

        // busy collision: second go two cycles after the first
        bus_write(2'd1, 32'h8001_0209);
        @(negedge clk);
        bus_write(2'd1, 32'h8001_030A);
        wait_idle("idle_collide");
        rd_lit(2'd0, "collide_err", 32'h0004_0000);
        bus_write(2'd2, 32'h0001_0300);
        rd_lit(2'd2, "collide_dropped", 32'h0);
        bus_write(2'd2, 32'h0001_0200);
        rd_lit(2'd2, "collide_first", 32'h9);
        bus_write(2'd0, 32'h2);

        // clear together with a busy reset-start: error must win
        bus_write(2'd1, 32'h8000_0001);
        bus_write(2'd0, 32'h3);
        wait_idle("idle_errwin");
        rd_lit(2'd0, "err_wins", 32'h0004_0000);
        bus_write(2'd0, 32'h2);

        // IDELAYCTRL reset then all ready
        bus_write(2'd0, 32'h1);
        n = 0;
        repeat (20) begin
            if (idelayctrl_rst_o === 1'b1) n++;
            @(negedge clk);
        end
        chk("rst_len", n, RL);
        repeat (6) @(negedge clk);
        rdy = '1;
        wait_idle("idle_rdy");
        rd_lit(2'd0, "rdy_ok", 32'h0000_003F);

        // one ready flag stuck low: timeout
        rdy = 6'h1F;
        bus_write(2'd0, 32'h1);
        n = 0;
        while (busy_o === 1'b1 && n < 3000) begin n++; @(negedge clk); end
        chk("timeout_busy_len", n, RL + TO);
        rd_lit(2'd0, "timeout_flag", 32'h0008_001F);
        bus_write(2'd0, 32'h2);
        rd_lit(2'd0, "timeout_clr", 32'h0000_001F);
        rdy = '1;

        // broadcast lane+channel, tap 0x1F
        bus_write(2'd1, 32'h8300_001F);
        @(negedge clk);
`ifdef RITC_IDELAY_BCAST_EN
        chk("bcast_ld", ld_o, {LDW{1'b1}});
`else
        chk("bcast_ld", ld_o, one);
`endif
        wait_idle("idle_bcast");
        bus_write(2'd2, 32'h0000_0000);
        rd_lit(2'd2, "bcast_0_0", 32'h1F);
        bus_write(2'd2, 32'h0005_0C00);
`ifdef RITC_IDELAY_BCAST_EN
        rd_lit(2'd2, "bcast_5_12", 32'h1F);
`else
        rd_lit(2'd2, "bcast_5_12", 32'h0);
`endif
        bus_write(2'd2, 32'h0002_0500);
        rd(2'd2, "bcast_2_5");

        // reset one cycle after go
        bus_write(2'd1, 32'h8004_0314);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ld", ld_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_cnt", cntvalue_o, 0);
        repeat (3) @(negedge clk);
        rd_lit(2'd2, "midrst_ptr0", 32'h0);
        rd_lit(2'd1, "midrst_cmd", 32'h0);
        bus_write(2'd2, 32'h0004_0300);
        rd_lit(2'd2, "midrst_shadow", 32'h0);
        bus_write(2'd2, 32'h0002_0500);
        rd_lit(2'd2, "midrst_shadow_2_5", 32'h0);

        // reset during IDELAYCTRL reset pulse
        bus_write(2'd0, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ctrl_rst", idelayctrl_rst_o, 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
